// File: rtl/mul_vec_pkg.sv
// +----------------------------------------------------------------------------+
// | mul_vec_pkg                                                                |
// | Shared types and sizing helpers for the bit-plane sequential multiplier.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mul_vec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Plane counter width; never narrower than one bit so WIDTH=1 still has a counter.
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic int plane_bits(input int planes, input int lanes);
    return planes * lanes;
  endfunction

  function automatic int acc_bits(input int width, input int lanes);
    return 2 * width * lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bitslice_add.sv
// +----------------------------------------------------------------------------+
// | bitslice_add                                                               |
// | Combinational plane-wise ripple adder: all lanes add in parallel, carries  |
// | ripple from plane to plane within each lane.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bitslice_add
  import mul_vec_pkg::*;
#(
  parameter int PLANES = 4,
  parameter int LANES  = 16
) (
  input  logic [plane_bits(PLANES, LANES)-1:0] x,
  input  logic [plane_bits(PLANES, LANES)-1:0] z,
  output logic [plane_bits(PLANES, LANES)-1:0] s
);

  logic [LANES-1:0] w_carry;
  logic [LANES-1:0] w_xp;
  logic [LANES-1:0] w_zp;

  // The carry out of the top plane is dropped: callers size PLANES so it is always zero.
  always_comb begin
    w_carry = '0;
    w_xp    = '0;
    w_zp    = '0;
    s       = '0;
    for (int p = 0; p < PLANES; p++) begin
      w_xp = x[p*LANES +: LANES];
      w_zp = z[p*LANES +: LANES];
      s[p*LANES +: LANES] = w_xp ^ w_zp ^ w_carry;
      w_carry = (w_xp & w_zp) | (w_carry & (w_xp ^ w_zp));
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_vec_seq.sv
// +----------------------------------------------------------------------------+
// | mul_vec_seq                                                                |
// | Bit-plane vector multiplier, one multiplier plane per cycle (shift-add).   |
// | Optional: MUL_VEC_EARLY_EXIT_EN finishes once remaining b planes are zero.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mul_vec_seq
  import mul_vec_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int LANES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*LANES-1:0]     a,
  input  logic [WIDTH*LANES-1:0]     b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH*LANES-1:0]   y,
  output logic                       busy
);

  localparam int c_cw   = count_width(WIDTH);
  localparam int c_opw  = plane_bits(WIDTH, LANES);
  localparam int c_accw = acc_bits(WIDTH, LANES);
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  state_t              r_state;
  state_t              w_next;
  logic [c_opw-1:0]    r_a;
  logic [c_opw-1:0]    r_b;
  logic [c_accw-1:0]   r_acc;
  logic [c_accw-1:0]   r_y;
  logic [c_cw-1:0]     r_count;
  logic                r_out_valid;

  logic [LANES-1:0]    w_bplane;
  logic [c_opw-1:0]    w_pp;
  logic [c_accw-1:0]   w_pp_shift;
  logic [c_accw-1:0]   w_sum;
  logic                w_last;

  assign w_bplane   = r_b[r_count*LANES +: LANES];
  assign w_pp       = r_a & {WIDTH{w_bplane}};
  // Partial product lands at plane offset count inside the double-width accumulator.
  assign w_pp_shift = {{c_opw{1'b0}}, w_pp} << (r_count * LANES);
  assign w_last     = (r_count == c_last);

  bitslice_add #(
    .PLANES (2 * WIDTH),
    .LANES  (LANES)
  ) u_add (
    .x (r_acc),
    .z (w_pp_shift),
    .s (w_sum)
  );

`ifdef MUL_VEC_EARLY_EXIT_EN
  logic [c_opw-1:0] w_rest;
  logic             w_rest_zero;
  assign w_rest      = r_b >> (r_count * LANES);
  assign w_rest_zero = (w_rest == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
`ifdef MUL_VEC_EARLY_EXIT_EN
        if (w_last || w_rest_zero) w_next = DONE;
`else
        if (w_last) w_next = DONE;
`endif
      end
      DONE: begin
        if (r_out_valid && out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // DONE spends one edge latching the result before presenting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        BUSY: begin
`ifdef MUL_VEC_EARLY_EXIT_EN
          if (!w_rest_zero) r_acc <= w_sum;
`else
          r_acc <= w_sum;
`endif
          r_count <= r_count + 1'b1;
        end
        DONE: begin
          if (!r_out_valid) begin
            r_y         <= r_acc;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;

endmodule

`default_nettype wire

// File: tb/tb_mul_vec_seq.sv
// +----------------------------------------------------------------------------+
// | tb_mul_vec_seq                                                             |
// | Scoreboard bench for mul_vec_seq at WIDTH=2/LANES=16 and WIDTH=8/LANES=4.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mul_vec_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv2 = 1'b0, or2 = 1'b0, ir2, ov2, busy2;
  logic [31:0] a2 = '0, b2 = '0;
  logic [63:0] y2;
  logic        iv8 = 1'b0, or8 = 1'b0, ir8, ov8, busy8;
  logic [31:0] a8 = '0, b8 = '0;
  logic [63:0] y8;

  mul_vec_seq #(.WIDTH(2), .LANES(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .y(y2), .busy(busy2)
  );

  mul_vec_seq #(.WIDTH(8), .LANES(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .y(y8), .busy(busy8)
  );

`ifdef MUL_VEC_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int          sel = 0;
  logic        obs_ir, obs_ov, obs_busy;
  logic [63:0] obs_y;

  always_comb begin
    obs_ir   = ir2;
    obs_ov   = ov2;
    obs_busy = busy2;
    obs_y    = y2;
    if (sel != 0) begin
      obs_ir   = ir8;
      obs_ov   = ov8;
      obs_busy = busy8;
      obs_y    = y8;
    end
  end

  typedef struct {
    logic [63:0] y;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [63:0] model_y(input int w, input int l, input logic [31:0] av,
                                          input logic [31:0] bv);
    logic [63:0] r;
    logic [31:0] va, vb;
    logic [63:0] p;
    r = '0;
    for (int lane = 0; lane < l; lane++) begin
      va = '0;
      vb = '0;
      for (int k = 0; k < w; k++) begin
        va[k] = av[k*l + lane];
        vb[k] = bv[k*l + lane];
      end
      p = 64'(va) * 64'(vb);
      for (int k = 0; k < 2*w; k++) r[k*l + lane] = p[k];
    end
    return r;
  endfunction

  function automatic int model_lat(input int w, input int l, input logic [31:0] bv);
    int h;
    int early;
    h = -1;
    for (int k = 0; k < w; k++)
      for (int lane = 0; lane < l; lane++)
        if (bv[k*l + lane]) h = k;
    early = ((h + 2 < w) ? h + 2 : w) + 1;
    return EARLY ? early : w + 1;
  endfunction

  task automatic drive(input int s, input logic v, input logic [31:0] av, input logic [31:0] bv);
    if (s == 0) begin
      iv2 = v; a2 = av; b2 = bv;
    end else begin
      iv8 = v; a8 = av; b8 = bv;
    end
  endtask

  task automatic set_or(input int s, input logic v);
    if (s == 0) or2 = v;
    else        or8 = v;
  endtask

  task automatic do_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                       input int hold, input string tag);
    int   edges;
    int   w, l;
    exp_t e, got;
    w = (s == 0) ? 2 : 8;
    l = (s == 0) ? 16 : 4;
    sel = s;
    @(negedge clk);
    drive(s, 1'b1, av, bv);
    n_vec++;
    if (obs_ir !== 1'b1) begin
      n_miss++; $display("FAIL %s in_ready_idle: got %b want 1", tag, obs_ir);
    end
    @(posedge clk);
    e.y   = model_y(w, l, av, bv);
    e.lat = model_lat(w, l, bv);
    sb.push_back(e);
    #1;
    drive(s, 1'b0, $urandom, $urandom);
    edges = 0;
    while (obs_ov !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        n_vec++;
        if (obs_busy !== (e.lat > 2)) begin
          n_miss++; $display("FAIL %s busy_first: got %b want %b", tag, obs_busy, e.lat > 2);
        end
      end
    end
    got = sb.pop_front();
    n_vec++;
    if (obs_ov !== 1'b1) begin
      n_miss++; $display("FAIL %s out_valid_timeout: got %b want 1", tag, obs_ov);
    end
    n_vec++;
    if (edges != got.lat) begin
      n_miss++; $display("FAIL %s latency: got %0d want %0d", tag, edges, got.lat);
    end
    n_vec++;
    if (obs_y !== got.y) begin
      n_miss++; $display("FAIL %s y: got %h want %h", tag, obs_y, got.y);
    end
    n_vec++;
    if (obs_ir !== 1'b0 || obs_busy !== 1'b0) begin
      n_miss++; $display("FAIL %s done_flags: got ir=%b busy=%b want 0 0", tag, obs_ir, obs_busy);
    end
    if (hold > 0) drive(s, 1'b1, $urandom, $urandom);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (obs_ov !== 1'b1 || obs_y !== got.y || obs_ir !== 1'b0) begin
        n_miss++;
        $display("FAIL %s hold: got v=%b y=%h ir=%b want 1 %h 0", tag, obs_ov, obs_y, obs_ir, got.y);
      end
    end
    drive(s, 1'b0, $urandom, $urandom);
    set_or(s, 1'b1);
    @(posedge clk);
    #1;
    set_or(s, 1'b0);
    n_vec++;
    if (obs_ov !== 1'b0 || obs_ir !== 1'b1 || obs_y !== got.y) begin
      n_miss++;
      $display("FAIL %s pop: got v=%b ir=%b y=%h want 0 1 %h", tag, obs_ov, obs_ir, obs_y, got.y);
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if (ir2 !== 1'b1 || ov2 !== 1'b0 || busy2 !== 1'b0 || y2 !== 64'h0) begin
      n_miss++; $display("FAIL reset2: got ir=%b ov=%b busy=%b y=%h want 1 0 0 0", ir2, ov2, busy2, y2);
    end
    n_vec++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || y8 !== 64'h0) begin
      n_miss++; $display("FAIL reset8: got ir=%b ov=%b busy=%b y=%h want 1 0 0 0", ir8, ov8, busy8, y8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_uniform();
    do_op(0, {16'hFFFF, 16'h0000}, {16'hFFFF, 16'hFFFF}, 0, "uniform");
    n_vec++;
    if (y2 !== 64'h0000_FFFF_FFFF_0000) begin
      n_miss++; $display("FAIL uniform_const: got %h want 0000ffffffff0000", y2);
    end
  endtask

  task automatic test_lanes();
    do_op(0, {16'h0001, 16'h0003}, {16'h0003, 16'h0001}, 0, "lanes");
    n_vec++;
    if (y2 !== 64'h0001_0000_0002_0001) begin
      n_miss++; $display("FAIL lanes_const: got %h want 0001000000020001", y2);
    end
  endtask

  task automatic test_backpressure();
    do_op(0, $urandom, $urandom, 10, "backpressure");
    do_op(0, $urandom, $urandom, 0, "after_bp");
  endtask

  task automatic test_reset_mid_busy();
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    drive(0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ov2 !== 1'b0 || y2 !== 64'h0 || ir2 !== 1'b1 || busy2 !== 1'b0) begin
      n_miss++; $display("FAIL mid_reset: got ov=%b y=%h ir=%b busy=%b want 0 0 1 0", ov2, y2, ir2, busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, $urandom, $urandom, 1, "post_reset");
  endtask

  task automatic test_wide();
    do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "wide");
    n_vec++;
    if (y8 !== 64'hFFFF_FFF0_0000_000F) begin
      n_miss++; $display("FAIL wide_const: got %h want fffffff00000000f", y8);
    end
  endtask

  task automatic test_early_exit();
    logic [31:0] av;
    av = $urandom;
    do_op(1, av, 32'h0000_000F, 0, "b_one");
    n_vec++;
    if (y8 !== {32'h0, av}) begin
      n_miss++; $display("FAIL b_one_y: got %h want %h", y8, {32'h0, av});
    end
    do_op(1, $urandom, 32'h0, 0, "b_zero");
    n_vec++;
    if (y8 !== 64'h0) begin
      n_miss++; $display("FAIL b_zero_y: got %h want 0", y8);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) do_op(0, $urandom, $urandom, 0, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      do_op(i % 2, $urandom, $urandom, $urandom_range(0, 3), "random");
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_lanes();
    test_reset_mid_busy();
    test_backpressure();
    test_wide();
    test_early_exit();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
